// File: rtl/instr_stream_receiver.sv
// rtl/instr_stream_receiver.sv - accepts instruction words into the instr FIFOs and starts the dispatcher per sequence

module instr_stream_receiver #(
    parameter logic [3:0]       END_OPC   = 4'b1111,
    parameter int               CNT_W     = 11,
    parameter logic [CNT_W-1:0] MAX_INSTR = CNT_W'(2047)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             app_en,
    input  logic [31:0]      app_instr,
    output logic             app_ack,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [31:0]      fifo_din,
    input  logic             dispatcher_busy,
    output logic             process_tr,
    output logic [CNT_W-1:0] instr_count,
    output logic             seq_overflow,
    output logic [1:0]       state_out
);

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_RECV     = 2'b01;
    localparam logic [1:0] S_DISPATCH = 2'b10;
    localparam logic [1:0] S_BUSY     = 2'b11;

    logic [1:0]       state;
    logic             accept;
    logic             xfer;
    logic             is_end;
    logic [CNT_W-1:0] cnt_next;

    // Upstream may hand over a word only while collecting a sequence (or starting one with the dispatcher idle)
    always_comb begin
        accept = ~fifo_full & (((state == S_IDLE) & ~dispatcher_busy) | (state == S_RECV));
    end

    assign app_ack    = app_en & accept;
    assign xfer       = app_en & app_ack;
    assign is_end     = (app_instr[31:28] == END_OPC);
    assign process_tr = (state == S_DISPATCH);
    assign state_out  = state;

    // Count of the sequence after this transfer: first word restarts it, otherwise saturate at MAX_INSTR
    always_comb begin
        cnt_next = instr_count;
        if (state == S_IDLE) begin
            cnt_next = CNT_W'(1);
        end else if (instr_count != MAX_INSTR) begin
            cnt_next = instr_count + CNT_W'(1);
        end
    end

    // FIFO write path, sequence counter, overflow flag and sequence FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= 32'h0;
            instr_count  <= '0;
            seq_overflow <= 1'b0;
        end else begin
            fifo_wr_en <= xfer;
            if (xfer) begin
                fifo_din    <= app_instr;
                instr_count <= cnt_next;
            end
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        state <= is_end ? S_DISPATCH : S_RECV;
                    end
                end
                S_RECV: begin
                    if (xfer && (is_end || (cnt_next == MAX_INSTR))) begin
                        state <= S_DISPATCH;
                        if (!is_end) begin
                            seq_overflow <= 1'b1;
                        end
                    end
                end
                S_DISPATCH: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (!dispatcher_busy && !fifo_wr_en) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_receiver.sv
// tb/tb_instr_stream_receiver.sv - randomized self-checking bench for instr_stream_receiver

module tb_instr_stream_receiver;

    localparam int         CNT_W = 11;
    localparam int         MAXI  = 4;
    localparam logic [3:0] ENDO  = 4'hF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             app_en = 1'b0;
    logic [31:0]      app_instr = 32'h0;
    logic             app_ack;
    logic             fifo_full = 1'b0;
    logic             fifo_wr_en;
    logic [31:0]      fifo_din;
    logic             dispatcher_busy = 1'b0;
    logic             process_tr;
    logic [CNT_W-1:0] instr_count;
    logic             seq_overflow;
    logic [1:0]       state_out;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 start pulse, 3 waiting for dispatcher
    int          m_phase;
    int          m_cnt;
    bit          m_ovf;
    bit          m_wr;
    logic [31:0] m_din;
    logic [31:0] sent_q[$];

    instr_stream_receiver #(.END_OPC(ENDO), .CNT_W(CNT_W), .MAX_INSTR(CNT_W'(MAXI))) dut (
        .clk(clk), .rst(rst), .app_en(app_en), .app_instr(app_instr), .app_ack(app_ack),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .dispatcher_busy(dispatcher_busy), .process_tr(process_tr),
        .instr_count(instr_count), .seq_overflow(seq_overflow), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_ovf = 0; m_wr = 0; m_din = 32'h0;
        sent_q.delete();
    endtask

    // One clock cycle: caller sets inputs just after a rising edge
    task automatic step();
        bit exp_ack, end_w, prev_wr;
        logic [31:0] w;
        #4;
        exp_ack = app_en && !fifo_full && ((m_phase == 0 && !dispatcher_busy) || m_phase == 1);
        check("app_ack", app_ack, exp_ack);
        if (app_en && app_ack) sent_q.push_back(app_instr);
        @(posedge clk);
        prev_wr = m_wr;
        m_wr = exp_ack;
        end_w = (app_instr[31:28] == ENDO);
        if (exp_ack) begin
            m_din = app_instr;
            if (m_phase == 0) m_cnt = 1;
            else if (m_cnt < MAXI) m_cnt = m_cnt + 1;
            if (m_phase == 0) m_phase = end_w ? 2 : 1;
            else if (end_w || m_cnt == MAXI) begin
                if (!end_w) m_ovf = 1;
                m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_phase = 3;
        end else if (m_phase == 3 && !dispatcher_busy && !prev_wr) begin
            m_phase = 0;
        end
        #1;
        check("fifo_wr_en", fifo_wr_en, m_wr);
        check("fifo_din", fifo_din, m_din);
        check("instr_count", instr_count, m_cnt);
        check("seq_overflow", seq_overflow, m_ovf);
        check("state_out", state_out, m_phase);
        check("process_tr", process_tr, m_phase == 2);
        if (process_tr) pulses++;
        if (fifo_wr_en) begin
            if (sent_q.size() == 0) check("fifo_unexpected_write", 1, 0);
            else begin
                w = sent_q.pop_front();
                check("fifo_order", fifo_din, w);
            end
        end
    endtask

    task automatic send(input logic [31:0] w);
        app_en = 1'b1; app_instr = w;
        step();
    endtask

    task automatic idle_cycles(input int n);
        app_en = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        #12;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_state", state_out, 0);
        check("rst_count", instr_count, 0);
        check("rst_wr", fifo_wr_en, 0);

        // Basic three-word sequence
        pulses = 0;
        send(32'h1000_0001); check("s1_state1", state_out, 2'b01);
        send(32'h2000_0002); check("s1_state2", state_out, 2'b01);
        send({ENDO, 28'h0}); check("s1_state3", state_out, 2'b10);
        check("s1_count", instr_count, 3);
        idle_cycles(1);      check("s1_state4", state_out, 2'b11);
        idle_cycles(2);
        check("s1_pulses", pulses, 1);

        // Backpressure mid-sequence
        send(32'h3000_0003);
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h4000_0004);
            check("s2_stall_wr", fifo_wr_en, 0);
        end
        fifo_full = 1'b0;
        send(32'h4000_0004);
        send({ENDO, 28'h5});
        check("s2_count", instr_count, 3);
        idle_cycles(3);

        // Dispatcher gating
        dispatcher_busy = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h5000_0000 + i);
        check("s3_idle_hold", state_out, 2'b00);
        dispatcher_busy = 1'b0;
        send({ENDO, 28'h6});
        dispatcher_busy = 1'b1;
        idle_cycles(1);
        for (int i = 0; i < 10; i++) send(32'h6000_0000 + i);
        check("s3_busy_hold", state_out, 2'b11);
        dispatcher_busy = 1'b0;
        idle_cycles(1);
        check("s3_back_idle", state_out, 2'b00);
        send(32'h7000_0007);
        check("s3_restart", instr_count, 1);
        send({ENDO, 28'h7});
        idle_cycles(3);

        // Overflow at MAX_INSTR, then a normal sequence keeps the sticky flag
        for (int i = 0; i < MAXI; i++) send(32'h1100_0000 + i);
        check("s4_dispatch", state_out, 2'b10);
        check("s4_ovf", seq_overflow, 1);
        idle_cycles(3);
        send(32'h2200_0000);
        send({ENDO, 28'h1});
        idle_cycles(3);
        check("s4_ovf_sticky", seq_overflow, 1);

        // Asynchronous reset between edges while collecting
        send(32'h3300_0000);
        send(32'h3300_0001);
        #2;
        rst = 1'b1; app_en = 1'b0;
        #1;
        check("s5_state", state_out, 0);
        check("s5_count", instr_count, 0);
        check("s5_ovf", seq_overflow, 0);
        check("s5_din", fifo_din, 0);
        check("s5_wr", fifo_wr_en, 0);
        check("s5_ptr", process_tr, 0);
        check("s5_ack", app_ack, 0);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        pulses = 0;
        send(32'h1000_0001);
        send(32'h2000_0002);
        send({ENDO, 28'h0});
        check("s5_count3", instr_count, 3);
        idle_cycles(3);
        check("s5_pulses", pulses, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            app_en = ($urandom_range(0, 9) < 7);
            app_instr = $urandom;
            if ($urandom_range(0, 4) == 0) app_instr[31:28] = ENDO;
            else if (app_instr[31:28] == ENDO) app_instr[31:28] = 4'h3;
            fifo_full = ($urandom_range(0, 4) == 0);
            dispatcher_busy = ($urandom_range(0, 9) < 3);
            step();
        end
        fifo_full = 1'b0; dispatcher_busy = 1'b0;
        idle_cycles(2);
        check("fifo_drained", sent_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
